id_exe_stage_reg: RTL and testbench
===================================

ID_EXE_STAGE_REG -- requirements
Module: id_exe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of pc/register operand fields.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 flush  input  1  taken branch in EX; kill instruction entering this register.
REQ-006 freeze  input  1  global pipeline hold (memory wait); register holds.
REQ-007 bubble  input  1  load-use hazard from hazard unit; insert NOP.
REQ-008 valid_in  input  1  ID stage holds a real instruction.
REQ-009 pc_in  input  DATA_W  PC+4 of decoded instruction.
REQ-010 ctrl_in  input  9  {wb_en, mem_r_en, mem_w_en, exe_cmd[3:0], b, s}.
REQ-011 val_rn_in, val_rm_in  input  DATA_W each  register file read data.
REQ-012 imm_in  input  1  operand2 is immediate.
REQ-013 shift_operand_in  input  12  raw shifter operand.
REQ-014 signed_imm_24_in  input  24  branch offset.
REQ-015 dest_in, src1_in, src2_in  input  4 each  destination and source register numbers.
REQ-016 two_src_in  input  1  instruction reads src2 (forwarding enable).
REQ-017 status_in  input  4  NZCV flags captured at decode.
REQ-018 Every *_in above (except flush/freeze/bubble) SHALL have a registered *_out output of identical width; src1_out, src2_out, two_src_out feed the forwarding unit as src1, src2, enable.

Function
REQ-019 Update priority per rising edge SHALL be: rst > flush > freeze > bubble > normal load.
REQ-020 Normal load (no rst/flush/freeze/bubble): every *_out <= its *_in; one-cycle latency.
REQ-021 flush SHALL zero every output (control, data, register numbers, valid_out) on that edge.
REQ-022 freeze (flush=0) SHALL hold every output unchanged, including while bubble=1.
REQ-023 bubble (flush=0, freeze=0) SHALL load ctrl_out, valid_out, two_src_out as 0 and all other outputs from inputs.
REQ-024 valid_in=0 under normal load SHALL force ctrl_out=0 and two_src_out=0; data fields still load.
REQ-025 Effective control invariant: valid_out=0 implies ctrl_out=0 and two_src_out=0 at all times.
REQ-026 dest_out SHALL be 0 whenever valid_out=0 is produced by rst or flush; on bubble it loads dest_in.
REQ-027 No combinational path from any input to any output.
REQ-028 flush and freeze asserted together: flush wins; register empties, no hold.
REQ-029 freeze held N cycles: outputs constant for N edges, resume load on first edge with freeze=0.
REQ-030 Block contains no state beyond the output registers; no counters, no internal FSM.

Reset
REQ-031 On rst edge all outputs SHALL be 0, regardless of flush/freeze/bubble.
REQ-032 rst asserted mid-freeze SHALL clear outputs; after release, first edge with freeze=0 loads normally.
REQ-033 Outputs undefined before first rst edge; bench SHALL not check them.

Verification
REQ-034 Normal: valid_in=1, ctrl_in=9'h1A5, pc_in=32'h10, dest_in=4'd3 -> next edge ctrl_out=9'h1A5, pc_out=32'h10, dest_out=3, valid_out=1.
REQ-035 Bubble: load as REQ-034 with bubble=1 -> ctrl_out=0, valid_out=0, two_src_out=0, pc_out=32'h10, dest_out=3.
REQ-036 Freeze: register holds ctrl_out=9'h1A5; freeze=1 for 3 cycles with changing inputs -> outputs unchanged all 3 edges; 4th edge freeze=0 loads new inputs.
REQ-037 Flush+freeze same cycle with nonzero contents -> next edge all outputs 0.
REQ-038 Reset mid-stream: rst=1 with flush=0, freeze=1, valid_in=1 -> all outputs 0; rst=0, freeze=0 -> inputs loaded next edge.
REQ-039 valid_in=0, ctrl_in=9'h1FF, two_src_in=1, val_rn_in=32'hDEADBEEF -> ctrl_out=0, two_src_out=0, val_rn_out=32'hDEADBEEF.

Source files
------------

// File: rtl/id_exe_stage_reg.sv
// ID/EX pipeline register: captures decoded instruction state for the execute stage.
// Update priority per edge is rst > flush > freeze > bubble > normal load.
module id_exe_stage_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              bubble,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [8:0]        ctrl_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic              two_src_in,
  input  logic [3:0]        status_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [8:0]        ctrl_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
  output logic              two_src_out,
  output logic [3:0]        status_out
);

  logic              r_valid;
  logic [DATA_W-1:0] r_pc;
  logic [8:0]        r_ctrl;
  logic [DATA_W-1:0] r_valRn;
  logic [DATA_W-1:0] r_valRm;
  logic              r_imm;
  logic [11:0]       r_shiftOperand;
  logic [23:0]       r_signedImm24;
  logic [3:0]        r_dest;
  logic [3:0]        r_src1;
  logic [3:0]        r_src2;
  logic              r_twoSrc;
  logic [3:0]        r_status;

  logic w_kill;
  logic w_live;

  assign w_kill = rst | flush;
  // Control survives only for a real instruction that is not being replaced by a bubble.
  assign w_live = valid_in & ~bubble;

  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_valid        <= 1'b0;
      r_pc           <= '0;
      r_ctrl         <= '0;
      r_valRn        <= '0;
      r_valRm        <= '0;
      r_imm          <= 1'b0;
      r_shiftOperand <= '0;
      r_signedImm24  <= '0;
      r_dest         <= '0;
      r_src1         <= '0;
      r_src2         <= '0;
      r_twoSrc       <= 1'b0;
      r_status       <= '0;
    end else if (!freeze) begin
      r_valid        <= w_live;
      r_pc           <= pc_in;
      r_ctrl         <= w_live ? ctrl_in : 9'd0;
      r_valRn        <= val_rn_in;
      r_valRm        <= val_rm_in;
      r_imm          <= imm_in;
      r_shiftOperand <= shift_operand_in;
      r_signedImm24  <= signed_imm_24_in;
      r_dest         <= dest_in;
      r_src1         <= src1_in;
      r_src2         <= src2_in;
      r_twoSrc       <= w_live & two_src_in;
      r_status       <= status_in;
    end
  end

  assign valid_out         = r_valid;
  assign pc_out            = r_pc;
  assign ctrl_out          = r_ctrl;
  assign val_rn_out        = r_valRn;
  assign val_rm_out        = r_valRm;
  assign imm_out           = r_imm;
  assign shift_operand_out = r_shiftOperand;
  assign signed_imm_24_out = r_signedImm24;
  assign dest_out          = r_dest;
  assign src1_out          = r_src1;
  assign src2_out          = r_src2;
  assign two_src_out       = r_twoSrc;
  assign status_out        = r_status;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg: directed scenarios plus randomized
// traffic compared against a rule-level model of the pipeline register.
module tb_id_exe_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [8:0]  ctrl;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [11:0] shOp;
    logic [23:0] off;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        twoSrc;
    logic [3:0]  status;
  } stage_t;

  logic clk = 1'b0;
  logic rst, flush, freeze, bubble;
  stage_t stim;
  stage_t observed;
  stage_t model;
  stage_t snapshot;
  int total = 0;
  int bad = 0;
  bit hasReset = 0;

  always #5 clk = ~clk;

  id_exe_stage_reg #(.DATA_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .freeze            (freeze),
    .bubble            (bubble),
    .valid_in          (stim.valid),
    .pc_in             (stim.pc),
    .ctrl_in           (stim.ctrl),
    .val_rn_in         (stim.rn),
    .val_rm_in         (stim.rm),
    .imm_in            (stim.imm),
    .shift_operand_in  (stim.shOp),
    .signed_imm_24_in  (stim.off),
    .dest_in           (stim.dest),
    .src1_in           (stim.src1),
    .src2_in           (stim.src2),
    .two_src_in        (stim.twoSrc),
    .status_in         (stim.status),
    .valid_out         (observed.valid),
    .pc_out            (observed.pc),
    .ctrl_out          (observed.ctrl),
    .val_rn_out        (observed.rn),
    .val_rm_out        (observed.rm),
    .imm_out           (observed.imm),
    .shift_operand_out (observed.shOp),
    .signed_imm_24_out (observed.off),
    .dest_out          (observed.dest),
    .src1_out          (observed.src1),
    .src2_out          (observed.src2),
    .two_src_out       (observed.twoSrc),
    .status_out        (observed.status)
  );

  task automatic checkOutput(input string tag, input logic [191:0] got, input logic [191:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Register contents after one edge, stated as the stage's rules:
  // reset/flush empty it, freeze keeps it, bubble or an invalid slot drops control only.
  function automatic stage_t nextState(stage_t cur, stage_t in, bit r, bit f, bit fr, bit b);
    stage_t n;
    if (r || f) return '0;
    if (fr) return cur;
    n = in;
    if (b || !in.valid) begin
      n.valid  = 1'b0;
      n.ctrl   = '0;
      n.twoSrc = 1'b0;
    end
    return n;
  endfunction

  function automatic stage_t randomStim();
    stage_t s;
    s.valid  = ($urandom_range(0, 4) != 0);
    s.pc     = $urandom;
    s.ctrl   = 9'($urandom);
    s.rn     = $urandom;
    s.rm     = $urandom;
    s.imm    = 1'($urandom);
    s.shOp   = 12'($urandom);
    s.off    = 24'($urandom);
    s.dest   = 4'($urandom);
    s.src1   = 4'($urandom);
    s.src2   = 4'($urandom);
    s.twoSrc = 1'($urandom);
    s.status = 4'($urandom);
    return s;
  endfunction

  // Drive inputs on the falling edge, confirm nothing leaks through before the
  // rising edge, then compare against the model just after it.
  task automatic applyStimulus(input string tag, input stage_t s, input bit r, input bit f,
                               input bit fr, input bit b);
    @(negedge clk);
    stim = s; rst = r; flush = f; freeze = fr; bubble = b;
    #1;
    if (hasReset) checkOutput({tag, "_nocomb"}, 192'(observed), 192'(model));
    @(posedge clk);
    model = nextState(model, s, r, f, fr, b);
    if (r) hasReset = 1;
    #1;
    if (hasReset) begin
      checkOutput(tag, 192'(observed), 192'(model));
      if (!observed.valid)
        checkOutput({tag, "_inv"}, 192'({observed.ctrl, observed.twoSrc}), 192'(0));
    end
  endtask

  initial begin
    stage_t s;
    stim = '0; rst = 0; flush = 0; freeze = 0; bubble = 0;
    model = '0;

    // Reset wins over everything else asserted with it.
    s = randomStim(); s.valid = 1;
    applyStimulus("reset", s, 1, 1, 1, 1);
    checkOutput("reset_zero", 192'(observed), 192'(0));

    s = '0; s.valid = 1; s.ctrl = 9'h1A5; s.pc = 32'h10; s.dest = 4'd3;
    applyStimulus("normal", s, 0, 0, 0, 0);
    checkOutput("normal_ctrl", 192'(observed.ctrl), 192'(9'h1A5));
    checkOutput("normal_pc", 192'(observed.pc), 192'(32'h10));
    checkOutput("normal_dest", 192'(observed.dest), 192'(4'd3));
    checkOutput("normal_valid", 192'(observed.valid), 192'(1));

    s.twoSrc = 1;
    applyStimulus("bubble", s, 0, 0, 0, 1);
    checkOutput("bubble_ctrl", 192'({observed.ctrl, observed.valid, observed.twoSrc}), 192'(0));
    checkOutput("bubble_pc", 192'(observed.pc), 192'(32'h10));
    checkOutput("bubble_dest", 192'(observed.dest), 192'(4'd3));

    s.twoSrc = 0;
    applyStimulus("preload", s, 0, 0, 0, 0);
    snapshot = observed;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("freeze", randomStim(), 0, 0, 1, (i == 1));
      checkOutput("freeze_hold", 192'(observed), 192'(snapshot));
    end
    s = randomStim(); s.valid = 1;
    applyStimulus("unfreeze", s, 0, 0, 0, 0);
    checkOutput("unfreeze_pc", 192'(observed.pc), 192'(s.pc));
    checkOutput("unfreeze_ctrl", 192'(observed.ctrl), 192'(s.ctrl));

    applyStimulus("flush_freeze", randomStim(), 0, 1, 1, 0);
    checkOutput("flush_freeze_zero", 192'(observed), 192'(0));

    s = randomStim(); s.valid = 1;
    applyStimulus("preload2", s, 0, 0, 0, 0);
    applyStimulus("rst_mid", s, 1, 0, 1, 0);
    checkOutput("rst_mid_zero", 192'(observed), 192'(0));
    s = randomStim(); s.valid = 1;
    applyStimulus("rst_release", s, 0, 0, 0, 0);
    checkOutput("rst_release_rn", 192'(observed.rn), 192'(s.rn));

    s = randomStim(); s.valid = 0; s.ctrl = 9'h1FF; s.twoSrc = 1; s.rn = 32'hDEADBEEF;
    applyStimulus("invalid", s, 0, 0, 0, 0);
    checkOutput("invalid_ctrl", 192'({observed.ctrl, observed.twoSrc}), 192'(0));
    checkOutput("invalid_rn", 192'(observed.rn), 192'(32'hDEADBEEF));

    for (int i = 0; i < 400; i++) begin
      applyStimulus("random", randomStim(),
                    ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
